// File: rtl/fp_normalize_round.sv
// fp_normalize_round
//   Post-add normalize and round for single-precision add/subtract.
//   Two registered stages with valid/ready handshake:
//     S1 normalizes the raw sum (carry right-shift or leading-zero left-shift).
//     S2 rounds to 24 bits and detects exponent overflow to infinity.
//   Build option: define NORM_ROUND_NEAREST_EVEN_EN for round-to-nearest-even;
//   otherwise the guard/round/sticky bits are truncated.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   in_sign               sign of the larger operand (passed through)
//   in_exponent[7:0]      biased exponent of the larger operand
//   in_sum[26:0]          {carry, significand[25:2] (hidden bit 25), guard, round}
//   in_sticky             OR of bits lost during alignment
//   in_flags[5:0]         {is_nan, is_inf, sign_special, x_is_zero, y_is_zero, do_subtract}
//   out_valid / out_ready downstream handshake
//   out_sign, out_exponent[7:0], out_mantissa[23:0] (hidden bit 23), out_flags[5:0]
module fp_normalize_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exponent,
  input  logic [26:0] in_sum,
  input  logic        in_sticky,
  input  logic [5:0]  in_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exponent,
  output logic [23:0] out_mantissa,
  output logic [5:0]  out_flags
);

  localparam int FLAG_IS_INF    = 4;
  localparam int FLAG_SIGN_SPEC = 3;

  // Leading-zero count of a 26-bit value; 26 when the value is zero.
  function automatic logic [4:0] lzc26(input logic [25:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd26;
    found = 1'b0;
    for (int i = 25; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(25 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic               vld_p1_q, vld_p2_q;
  logic               in_fire, s2_en, s2_load;

  logic               sign_p1_d, sign_p1_q;
  logic signed [9:0]  exp_p1_d, exp_p1_q;
  logic [23:0]        sig_p1_d, sig_p1_q;
  logic               grd_p1_d, grd_p1_q;
  logic               rnd_p1_d, rnd_p1_q;
  logic               stk_p1_d, stk_p1_q;
  logic [5:0]         flags_p1_d, flags_p1_q;

  logic               sign_p2_q;
  logic [7:0]         exp_p2_d, exp_p2_q;
  logic [23:0]        mant_p2_d, mant_p2_q;
  logic [5:0]         flags_p2_d, flags_p2_q;

  logic signed [9:0]  exp_ext, exp_lz;
  logic [4:0]         lz;
  logic [25:0]        shl;
  logic [24:0]        mant_rnd;
  logic signed [9:0]  exp_rnd;

  // S2 can take a new item when empty or when its current item leaves.
  assign s2_en    = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || s2_en;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s2_en && vld_p1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (in_fire) begin
        vld_p1_q <= 1'b1;
      end else if (s2_en) begin
        vld_p1_q <= 1'b0;
      end
      if (s2_en) begin
        vld_p2_q <= vld_p1_q;
      end
    end
  end

  // ---- stage boundary: input -> S1 (normalize) ----
  always_comb begin
    exp_ext    = signed'({2'b00, in_exponent});
    lz         = lzc26(in_sum[25:0]);
    shl        = in_sum[25:0] << lz;
    exp_lz     = exp_ext - signed'({5'b00000, lz});
    sign_p1_d  = in_sign;
    flags_p1_d = in_flags;
    exp_p1_d   = '0;
    sig_p1_d   = '0;
    grd_p1_d   = 1'b0;
    rnd_p1_d   = 1'b0;
    stk_p1_d   = 1'b0;
    if (in_sum[26]) begin
      // Carry out of the add: drop one bit to the right, it joins sticky.
      exp_p1_d = exp_ext + 10'sd1;
      sig_p1_d = in_sum[26:3];
      grd_p1_d = in_sum[2];
      rnd_p1_d = in_sum[1];
      stk_p1_d = in_sticky | in_sum[0];
    end else if ((in_sum[25:0] != 26'd0) && (exp_lz > 10'sd0)) begin
      exp_p1_d = exp_lz;
      sig_p1_d = shl[25:2];
      grd_p1_d = shl[1];
      rnd_p1_d = shl[0];
      stk_p1_d = in_sticky;
    end
    // Otherwise zero or underflow: flush to exponent 0, mantissa 0.
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_p1_q  <= 1'b0;
      exp_p1_q   <= '0;
      sig_p1_q   <= '0;
      grd_p1_q   <= 1'b0;
      rnd_p1_q   <= 1'b0;
      stk_p1_q   <= 1'b0;
      flags_p1_q <= '0;
    end else if (in_fire) begin
      sign_p1_q  <= sign_p1_d;
      exp_p1_q   <= exp_p1_d;
      sig_p1_q   <= sig_p1_d;
      grd_p1_q   <= grd_p1_d;
      rnd_p1_q   <= rnd_p1_d;
      stk_p1_q   <= stk_p1_d;
      flags_p1_q <= flags_p1_d;
    end
  end

  // ---- stage boundary: S1 -> S2 (round) ----
`ifdef NORM_ROUND_NEAREST_EVEN_EN
  function automatic logic [24:0] round_mant(input logic [23:0] sig, input logic g,
                                             input logic r, input logic s);
    return {1'b0, sig} + 25'(g && (r || s || sig[0]));
  endfunction
  assign mant_rnd = round_mant(sig_p1_q, grd_p1_q, rnd_p1_q, stk_p1_q);
`else
  function automatic logic [24:0] round_mant(input logic [23:0] sig);
    return {1'b0, sig};
  endfunction
  logic unused_grs;
  assign unused_grs = grd_p1_q ^ rnd_p1_q ^ stk_p1_q;
  assign mant_rnd   = round_mant(sig_p1_q);
`endif

  always_comb begin
    exp_rnd    = exp_p1_q;
    mant_p2_d  = mant_rnd[23:0];
    flags_p2_d = flags_p1_q;
    if (mant_rnd[24]) begin
      mant_p2_d = 24'h800000;
      exp_rnd   = exp_p1_q + 10'sd1;
    end
    exp_p2_d = exp_rnd[7:0];
    if (exp_rnd >= 10'sd255) begin
      exp_p2_d                   = 8'hFF;
      mant_p2_d                  = '0;
      flags_p2_d[FLAG_IS_INF]    = 1'b1;
      flags_p2_d[FLAG_SIGN_SPEC] = sign_p1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_p2_q  <= 1'b0;
      exp_p2_q   <= '0;
      mant_p2_q  <= '0;
      flags_p2_q <= '0;
    end else if (s2_load) begin
      sign_p2_q  <= sign_p1_q;
      exp_p2_q   <= exp_p2_d;
      mant_p2_q  <= mant_p2_d;
      flags_p2_q <= flags_p2_d;
    end
  end

  // ---- stage boundary: S2 -> output ----
  assign out_valid    = vld_p2_q;
  assign out_sign     = sign_p2_q;
  assign out_exponent = exp_p2_q;
  assign out_mantissa = mant_p2_q;
  assign out_flags    = flags_p2_q;

endmodule
